// File: rtl/uart_interface_alu_pkg.sv
// Shared types and constants for the UART <-> ALU control block.
// Holds default widths, FSM state encoding and ALU opcode values.
package uart_interface_alu_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;

   localparam logic [1:0] WAIT_A  = 2'd0;
   localparam logic [1:0] WAIT_B  = 2'd1;
   localparam logic [1:0] WAIT_OP = 2'd2;
   localparam logic [1:0] SEND    = 2'd3;

   localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
   localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
   localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
   localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
   localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
   localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
   localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
   localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/uart_interface_alu.sv
// Collects A, B, opcode bytes from the UART RX, drives the ALU, and
// sends the ALU result to the UART TX with a one-cycle done strobe.
// Ports: i_clock, i_reset (sync, active-high), i_rx_data/i_rx_done,
//        i_alu_result, o_dato_A/o_dato_B/o_OP, o_interface_data/_done.
module uart_interface_alu
   import uart_interface_alu_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_OP   = NB_OP_DEF
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_dato_A,
   output logic [NB_DATA-1:0] o_dato_B,
   output logic [NB_OP-1:0]   o_OP,
   output logic [NB_DATA-1:0] o_interface_data,
   output logic               o_interface_done
);

   logic [1:0] state;
   logic [1:0] next_state;

   always_comb begin
      next_state = state;
      unique case (state)
         WAIT_A:  if (i_rx_done) next_state = WAIT_B;
         WAIT_B:  if (i_rx_done) next_state = WAIT_OP;
         WAIT_OP: if (i_rx_done) next_state = SEND;
         SEND:    next_state = WAIT_A;
         default: next_state = WAIT_A;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) state <= WAIT_A;
      else         state <= next_state;
   end

   // Per-state load enables; operands persist across transactions.
   logic ld_a, ld_b, ld_op, ld_tx;
   assign ld_a  = (state == WAIT_A)  && i_rx_done;
   assign ld_b  = (state == WAIT_B)  && i_rx_done;
   assign ld_op = (state == WAIT_OP) && i_rx_done;
   assign ld_tx = (state == SEND);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_dato_A         <= '0;
         o_dato_B         <= '0;
         o_OP             <= '0;
         o_interface_data <= '0;
         o_interface_done <= 1'b0;
      end else begin
         if (ld_a)  o_dato_A <= i_rx_data;
         if (ld_b)  o_dato_B <= i_rx_data;
         if (ld_op) o_OP     <= i_rx_data[NB_OP-1:0];
         if (ld_tx) o_interface_data <= i_alu_result;
         o_interface_done <= ld_tx;
      end
   end

endmodule

// File: tb/tb_uart_interface_alu.sv
// Directed self-checking bench for uart_interface_alu.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_interface_alu;
   import uart_interface_alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] alu;
   logic [7:0] dato_a, dato_b, tx_data;
   logic [5:0] op;
   logic       tx_done;

   int total  = 0;
   int passed = 0;
   int pulses;

   always #5 clk = ~clk;

   uart_interface_alu dut (
      .i_clock          (clk),
      .i_reset          (rst),
      .i_rx_data        (rx_data),
      .i_rx_done        (rx_done),
      .i_alu_result     (alu),
      .o_dato_A         (dato_a),
      .o_dato_B         (dato_b),
      .o_OP             (op),
      .o_interface_data (tx_data),
      .o_interface_done (tx_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rx_data = '0; rx_done = 1'b0; alu = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_a", dato_a, 0);
      chk("rst_b", dato_b, 0);
      chk("rst_op", op, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_state", dut.state, WAIT_A);

      alu = 8'hFF;
      send(8'hF0);
      chk("nom_a", dato_a, 8'hF0);
      chk("nom_st_b", dut.state, WAIT_B);
      send(8'h0F);
      chk("nom_b", dato_b, 8'h0F);
      chk("nom_st_op", dut.state, WAIT_OP);
      send(8'h24);
      chk("nom_op", op, 6'b100100);
      chk("nom_st_send", dut.state, SEND);
      chk("nom_done_early", tx_done, 0);
      @(negedge clk);
      chk("nom_done", tx_done, 1);
      chk("nom_data", tx_data, 8'hFF);
      chk("nom_st_a", dut.state, WAIT_A);
      @(negedge clk);
      chk("nom_done_off", tx_done, 0);
      chk("nom_data_hold", tx_data, 8'hFF);
      chk("nom_a_hold", dato_a, 8'hF0);

      alu = 8'hAA;
      send(8'h11); send(8'h22); send(8'hE5);
      chk("trunc_op", op, 6'b100101);
      @(negedge clk);
      chk("trunc_data", tx_data, 8'hAA);
      @(negedge clk);

      send(8'h11); send(8'h22);
      rst = 1'b1; rx_done = 1'b1; rx_data = 8'h77;
      @(negedge clk);
      rst = 1'b0; rx_done = 1'b0;
      chk("mid_rst_state", dut.state, WAIT_A);
      chk("mid_rst_a", dato_a, 0);
      chk("mid_rst_b", dato_b, 0);
      alu = 8'h5A;
      send(8'h33); send(8'h44); send(8'h20);
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (tx_done) pulses++;
      end
      chk("mid_pulses", pulses, 1);
      chk("mid_a", dato_a, 8'h33);
      chk("mid_b", dato_b, 8'h44);
      chk("mid_op", op, 6'h20);
      chk("mid_data", tx_data, 8'h5A);

      send(8'h01);
      repeat (10) @(negedge clk);
      chk("idle_st_b", dut.state, WAIT_B);
      chk("idle_a", dato_a, 8'h01);
      send(8'h02);
      repeat (10) @(negedge clk);
      chk("idle_st_op", dut.state, WAIT_OP);
      chk("idle_b", dato_b, 8'h02);
      alu = 8'hC3;
      send(8'h03);
      @(negedge clk);
      chk("idle_done", tx_done, 1);
      chk("idle_data", tx_data, 8'hC3);
      @(negedge clk);

      alu = 8'h3C;
      send(8'h10); send(8'h20); send(8'h21);
      @(negedge clk);
      chk("b2b1_done", tx_done, 1);
      chk("b2b1_data", tx_data, 8'h3C);
      alu = 8'h77;
      send(8'h30);
      chk("b2b2_a", dato_a, 8'h30);
      chk("b2b2_done_off", tx_done, 0);
      send(8'h40); send(8'h22);
      chk("b2b2_op", op, 6'h22);
      @(negedge clk);
      chk("b2b2_done", tx_done, 1);
      chk("b2b2_data", tx_data, 8'h77);
      @(negedge clk);

      alu = 8'h99;
      send(8'h0A); send(8'h0B); send(8'h26);
      send(8'h55);
      chk("snd_done", tx_done, 1);
      chk("snd_data", tx_data, 8'h99);
      chk("snd_state", dut.state, WAIT_A);
      chk("snd_a", dato_a, 8'h0A);
      @(negedge clk);
      chk("snd_state2", dut.state, WAIT_A);
      chk("snd_a2", dato_a, 8'h0A);
      chk("snd_done_off", tx_done, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
